// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the instruction encoder/loader and the decoder:
// operation select codes, primary opcodes, R-type function codes and word builders.
package mips_isa_pkg;

  // Symbolic operation selects presented on the request interface (13-15 are illegal)
  typedef enum logic [3:0] {
    OPSEL_NOP  = 4'd0,
    OPSEL_ADD  = 4'd1,
    OPSEL_SUB  = 4'd2,
    OPSEL_AND  = 4'd3,
    OPSEL_OR   = 4'd4,
    OPSEL_SLT  = 4'd5,
    OPSEL_ADDI = 4'd6,
    OPSEL_ANDI = 4'd7,
    OPSEL_ORI  = 4'd8,
    OPSEL_SLTI = 4'd9,
    OPSEL_J    = 4'd10,
    OPSEL_LW   = 4'd11,
    OPSEL_SW   = 4'd12
  } op_sel_e;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OPC_R    = 6'h00;
  localparam logic [5:0] OPC_J    = 6'h02;
  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI  = 6'h0D;
  localparam logic [5:0] OPC_LW   = 6'h23;
  localparam logic [5:0] OPC_SW   = 6'h2B;

  // R-type function codes (instruction bits 5:0)
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // R-type word: shamt is always zero for the supported operations
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_R, rs, rt, rd, 5'd0, funct};
  endfunction

  // I-type word: the immediate is placed raw, extension is the decoder's job
  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_encode.sv
// Combinational instruction encoder: operation select plus register/immediate/target
// fields in, 32-bit MIPS word out, with flags for illegal selects and jumps.
module instr_word_encode
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        is_jump_o
);

  // Map each operation select to its encoded word; unknown selects flag illegal
  always_comb begin
    word_o    = 32'h0000_0000;
    illegal_o = 1'b0;
    is_jump_o = 1'b0;
    case (op_i)
      OPSEL_NOP:  word_o = 32'h0000_0000;
      OPSEL_ADD:  word_o = r_word(rs_i, rt_i, rd_i, FN_ADD);
      OPSEL_SUB:  word_o = r_word(rs_i, rt_i, rd_i, FN_SUB);
      OPSEL_AND:  word_o = r_word(rs_i, rt_i, rd_i, FN_AND);
      OPSEL_OR:   word_o = r_word(rs_i, rt_i, rd_i, FN_OR);
      OPSEL_SLT:  word_o = r_word(rs_i, rt_i, rd_i, FN_SLT);
      OPSEL_ADDI: word_o = i_word(OPC_ADDI, rs_i, rt_i, imm_i);
      OPSEL_ANDI: word_o = i_word(OPC_ANDI, rs_i, rt_i, imm_i);
      OPSEL_ORI:  word_o = i_word(OPC_ORI, rs_i, rt_i, imm_i);
      OPSEL_SLTI: word_o = i_word(OPC_SLTI, rs_i, rt_i, imm_i);
      OPSEL_LW:   word_o = i_word(OPC_LW, rs_i, rt_i, imm_i);
      OPSEL_SW:   word_o = i_word(OPC_SW, rs_i, rt_i, imm_i);
      OPSEL_J: begin
        word_o    = {OPC_J, target_i};
        is_jump_o = 1'b1;
      end
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts symbolic instruction requests, encodes them and
// streams the words into instruction memory, optionally padding each jump with a nop.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int AW       = 8,
  parameter int DEPTH    = 256,
  parameter bit PAD_JUMP = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Restart,
  input  logic          InValid,
  output logic          InReady,
  input  logic [3:0]    InOp,
  input  logic [4:0]    InRs,
  input  logic [4:0]    InRt,
  input  logic [4:0]    InRd,
  input  logic [15:0]   InImm,
  input  logic [25:0]   InTarget,
  output logic          MemWE,
  output logic [AW-1:0] MemAddr,
  output logic [31:0]   MemData,
  output logic          Full,
  output logic          Err,
  output logic [AW:0]   WordCount
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_PAD   = 3'd2,
    ST_ERR   = 3'd3,
    ST_FULL  = 3'd4
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_MAX   = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          full_q, full_d;
  logic          jump_q, jump_d;
  logic [AW:0]   count_q, count_d;

  logic [31:0]   enc_word_s;
  logic          enc_illegal_s;
  logic          enc_jump_s;
  logic          ready_s;
  logic          accept_s;
  logic          at_last_s;
  logic          pad_due_s;

  instr_word_encode u_encode (
    .op_i      (InOp),
    .rs_i      (InRs),
    .rt_i      (InRt),
    .rd_i      (InRd),
    .imm_i     (InImm),
    .target_i  (InTarget),
    .word_o    (enc_word_s),
    .illegal_o (enc_illegal_s),
    .is_jump_o (enc_jump_s)
  );

  // The word being written sits in the last slot; a jump being written needs a pad
  assign at_last_s = (addr_q == LAST_ADDR);
  assign pad_due_s = jump_q && PAD_JUMP;
  assign accept_s  = InValid && ready_s;
  assign InReady   = ready_s;

  // Ready: always in IDLE, in WRITE only when the next slot is free for a new word
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_IDLE:  ready_s = 1'b1;
      ST_WRITE: ready_s = !at_last_s && !pad_due_s;
      default:  ready_s = 1'b0;
    endcase
    ready_s = ready_s && !Restart;
  end

  // Next-state logic; Restart cancels any pending pad and returns to IDLE
  always_comb begin
    state_d = state_q;
    if (Restart) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_d = enc_illegal_s ? ST_ERR : ST_WRITE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (at_last_s) begin
            state_d = ST_FULL;
          end else if (pad_due_s) begin
            state_d = ST_PAD;
          end else if (accept_s) begin
            state_d = enc_illegal_s ? ST_ERR : ST_WRITE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PAD:  state_d = at_last_s ? ST_FULL : ST_IDLE;
        ST_ERR:  state_d = ST_IDLE;
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the state being entered
  always_comb begin
    we_d   = (state_d == ST_WRITE) || (state_d == ST_PAD);
    data_d = (state_d == ST_WRITE) ? enc_word_s : 32'h0000_0000;
    err_d  = (state_d == ST_ERR);
    full_d = (state_d == ST_FULL);
    jump_d = (state_d == ST_WRITE) && enc_jump_s;
    addr_d = addr_q;
    count_d = count_q;
    if (Restart) begin
      addr_d  = {AW{1'b0}};
      count_d = {(AW + 1){1'b0}};
    end else begin
      // Advance past a completed write, holding at the last slot (no wrap)
      if (we_q && !at_last_s) begin
        addr_d = addr_q + ADDR_ONE;
      end else begin
        addr_d = addr_q;
      end
      if (we_d && (count_q != CNT_MAX)) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= {AW{1'b0}};
      data_q  <= 32'h0000_0000;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      jump_q  <= 1'b0;
      count_q <= {(AW + 1){1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      full_q  <= full_d;
      jump_q  <= jump_d;
      count_q <= count_d;
    end
  end

  assign MemWE     = we_q;
  assign MemAddr   = addr_q;
  assign MemData   = data_q;
  assign Full      = full_q;
  assign Err       = err_q;
  assign WordCount = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Testbench for instr_encoder_loader: directed scenarios plus a randomized fill of the
// whole memory checked against a behavioural model of the expected write stream.
module tb_instr_encoder_loader;

  logic        Clk = 1'b0;
  logic        Reset, Restart, InValid;
  logic [3:0]  InOp;
  logic [4:0]  InRs, InRt, InRd;
  logic [15:0] InImm;
  logic [25:0] InTarget;
  logic        InReady, MemWE, Full, Err;
  logic [7:0]  MemAddr;
  logic [31:0] MemData;
  logic [8:0]  WordCount;

  // Small instance (DEPTH=4) for the full-boundary scenario
  logic        Restart4, InValid4, InReady4, MemWE4, Full4, Err4;
  logic [3:0]  InOp4;
  logic [1:0]  MemAddr4;
  logic [31:0] MemData4;
  logic [2:0]  WordCount4;

  int checks = 0;
  int errors = 0;

  logic [39:0] cap_q[$];
  bit          mon_en = 1'b0;
  int          err_seen = 0;

  always #5 Clk = ~Clk;

  instr_encoder_loader #(.AW(8), .DEPTH(256), .PAD_JUMP(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .Restart(Restart), .InValid(InValid), .InReady(InReady),
    .InOp(InOp), .InRs(InRs), .InRt(InRt), .InRd(InRd), .InImm(InImm), .InTarget(InTarget),
    .MemWE(MemWE), .MemAddr(MemAddr), .MemData(MemData), .Full(Full), .Err(Err),
    .WordCount(WordCount)
  );

  instr_encoder_loader #(.AW(2), .DEPTH(4), .PAD_JUMP(1'b1)) dut4 (
    .Clk(Clk), .Reset(Reset), .Restart(Restart4), .InValid(InValid4), .InReady(InReady4),
    .InOp(InOp4), .InRs(InRs), .InRt(InRt), .InRd(InRd), .InImm(InImm), .InTarget(InTarget),
    .MemWE(MemWE4), .MemAddr(MemAddr4), .MemData(MemData4), .Full(Full4), .Err(Err4),
    .WordCount(WordCount4)
  );

  // Record every memory write and error pulse of the main instance while enabled
  always @(negedge Clk) begin
    if (mon_en) begin
      if (MemWE) cap_q.push_back({MemAddr, MemData});
      if (Err) err_seen++;
    end
  end

  // Reference encoding built from field positions with plain arithmetic
  function automatic logic [31:0] model_word(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] base_r, base_i;
    base_r = 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(rd) * 32'd2048;
    base_i = 32'(rs) * 32'd2097152 + 32'(rt) * 32'd65536 + 32'(imm);
    case (op)
      4'd1:    return base_r + 32'h20;
      4'd2:    return base_r + 32'h22;
      4'd3:    return base_r + 32'h24;
      4'd4:    return base_r + 32'h25;
      4'd5:    return base_r + 32'h2A;
      4'd6:    return 32'h2000_0000 + base_i;
      4'd7:    return 32'h3000_0000 + base_i;
      4'd8:    return 32'h3400_0000 + base_i;
      4'd9:    return 32'h2800_0000 + base_i;
      4'd10:   return 32'h0800_0000 + 32'(tgt);
      4'd11:   return 32'h8C00_0000 + base_i;
      4'd12:   return 32'hAC00_0000 + base_i;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    InValid = 1'b1; InOp = op; InRs = rs; InRt = rt; InRd = rd; InImm = imm; InTarget = tgt;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Restart = 1'b0; InValid = 1'b0; Restart4 = 1'b0; InValid4 = 1'b0;
    step();
    step();
    Reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Restart = 1'b0; InValid = 1'b0; Restart4 = 1'b0; InValid4 = 1'b0;
    InOp = 4'd0; InOp4 = 4'd0; InRs = 5'd0; InRt = 5'd0; InRd = 5'd0; InImm = 16'd0; InTarget = 26'd0;
    step();
    step();
    checks++; if (MemWE !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", MemWE); end
    checks++; if (MemAddr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", MemAddr); end
    checks++; if (MemData !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", MemData); end
    checks++; if (Full !== 1'b0 || Err !== 1'b0) begin errors++; $display("FAIL reset_flags got full=%b err=%b want 0 0", Full, Err); end
    checks++; if (WordCount !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", WordCount); end
    Reset = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", InReady); end
  endtask

  task automatic test_add();
    do_reset();
    drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    InValid = 1'b0;
    checks++; if (MemWE !== 1'b1 || MemAddr !== 8'd0) begin errors++; $display("FAIL add_we_addr got we=%b addr=%0d want 1 0", MemWE, MemAddr); end
    checks++; if (MemData !== 32'h0022_1820) begin errors++; $display("FAIL add_data got %h want 00221820", MemData); end
    checks++; if (WordCount !== 9'd1) begin errors++; $display("FAIL add_count got %0d want 1", WordCount); end
    step();
    checks++; if (MemWE !== 1'b0 || MemAddr !== 8'd1) begin errors++; $display("FAIL add_after got we=%b addr=%0d want 0 1", MemWE, MemAddr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w[3];
    exp_w[0] = 32'h2022_FFFF; exp_w[1] = 32'h8FA8_0004; exp_w[2] = 32'hAFA8_0008;
    do_reset();
    drive(4'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(4'd11, 5'd29, 5'd8, 5'd0, 16'd4, 26'h0);
      else if (i == 1) drive(4'd12, 5'd29, 5'd8, 5'd0, 16'd8, 26'h0);
      else InValid = 1'b0;
      checks++; if (MemWE !== 1'b1 || MemAddr !== 8'(i) || MemData !== exp_w[i]) begin
        errors++; $display("FAIL b2b_word%0d got we=%b %h@%0d want 1 %h@%0d", i, MemWE, MemData, MemAddr, exp_w[i], i); end
      if (i < 2) begin
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b want 1", i, InReady); end
      end
      step();
    end
    checks++; if (MemWE !== 1'b0 || WordCount !== 9'd3) begin errors++; $display("FAIL b2b_end got we=%b count=%0d want 0 3", MemWE, WordCount); end
  endtask

  task automatic test_jump_pad();
    do_reset();
    drive(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
    step();
    checks++; if (MemWE !== 1'b1 || MemAddr !== 8'd0 || MemData !== 32'h0800_0100) begin
      errors++; $display("FAIL j_word got we=%b %h@%0d want 1 08000100@0", MemWE, MemData, MemAddr); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL j_ready got %b want 0", InReady); end
    drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    step();
    checks++; if (MemWE !== 1'b1 || MemAddr !== 8'd1 || MemData !== 32'h0) begin
      errors++; $display("FAIL j_pad got we=%b %h@%0d want 1 00000000@1", MemWE, MemData, MemAddr); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL pad_ready got %b want 0", InReady); end
    step();
    checks++; if (MemWE !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL post_pad got we=%b ready=%b want 0 1", MemWE, InReady); end
    step();
    InValid = 1'b0;
    checks++; if (MemWE !== 1'b1 || MemAddr !== 8'd2 || MemData !== 32'h0022_1820) begin
      errors++; $display("FAIL j_next got we=%b %h@%0d want 1 00221820@2", MemWE, MemData, MemAddr); end
    checks++; if (WordCount !== 9'd3) begin errors++; $display("FAIL j_count got %0d want 3", WordCount); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(4'd14, 5'd3, 5'd4, 5'd5, 16'h1234, 26'h0);
    step();
    InValid = 1'b0;
    checks++; if (Err !== 1'b1 || MemWE !== 1'b0) begin errors++; $display("FAIL ill_err got err=%b we=%b want 1 0", Err, MemWE); end
    checks++; if (InReady !== 1'b0 || MemAddr !== 8'd0) begin errors++; $display("FAIL ill_ready got ready=%b addr=%0d want 0 0", InReady, MemAddr); end
    step();
    checks++; if (Err !== 1'b0 || InReady !== 1'b1) begin errors++; $display("FAIL ill_after got err=%b ready=%b want 0 1", Err, InReady); end
    checks++; if (WordCount !== 9'd0 || MemWE !== 1'b0) begin errors++; $display("FAIL ill_count got count=%0d we=%b want 0 0", WordCount, MemWE); end
  endtask

  task automatic test_restart();
    do_reset();
    // Restart in the same cycle as a valid request blocks the accept
    drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    Restart = 1'b1;
    #1;
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL rst_same_ready got %b want 0", InReady); end
    step();
    Restart = 1'b0;
    InValid = 1'b0;
    checks++; if (MemWE !== 1'b0 || WordCount !== 9'd0) begin errors++; $display("FAIL rst_same_noacc got we=%b count=%0d want 0 0", MemWE, WordCount); end
    // Restart during a jump write completes that write but cancels the pad
    drive(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3);
    step();
    InValid = 1'b0;
    Restart = 1'b1;
    #1;
    checks++; if (MemWE !== 1'b1 || MemData !== 32'h0800_0003) begin errors++; $display("FAIL rst_write got we=%b data=%h want 1 08000003", MemWE, MemData); end
    step();
    Restart = 1'b0;
    #1;
    checks++; if (MemWE !== 1'b0 || MemAddr !== 8'd0 || WordCount !== 9'd0) begin
      errors++; $display("FAIL rst_cancel got we=%b addr=%0d count=%0d want 0 0 0", MemWE, MemAddr, WordCount); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", InReady); end
    // Reset during the pad cycle drops the strobe at the next edge
    drive(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h7);
    step();
    InValid = 1'b0;
    step();
    checks++; if (MemWE !== 1'b1 || MemAddr !== 8'd1) begin errors++; $display("FAIL pad_before_reset got we=%b addr=%0d want 1 1", MemWE, MemAddr); end
    Reset = 1'b1;
    step();
    checks++; if (MemWE !== 1'b0 || MemAddr !== 8'd0 || MemData !== 32'h0 || WordCount !== 9'd0 || Full !== 1'b0 || Err !== 1'b0) begin
      errors++; $display("FAIL reset_pad got we=%b addr=%0d data=%h count=%0d full=%b err=%b want all 0", MemWE, MemAddr, MemData, WordCount, Full, Err); end
    Reset = 1'b0;
  endtask

  task automatic test_full_depth4();
    do_reset();
    InValid4 = 1'b1; InOp4 = 4'd1; InRs = 5'd1; InRt = 5'd2; InRd = 5'd3; InTarget = 26'h100;
    step();
    step();
    step();
    InOp4 = 4'd10;
    checks++; if (InReady4 !== 1'b1 || MemAddr4 !== 2'd2) begin errors++; $display("FAIL d4_ready got ready=%b addr=%0d want 1 2", InReady4, MemAddr4); end
    step();
    InValid4 = 1'b0;
    checks++; if (MemWE4 !== 1'b1 || MemAddr4 !== 2'd3 || MemData4 !== 32'h0800_0100) begin
      errors++; $display("FAIL d4_jword got we=%b %h@%0d want 1 08000100@3", MemWE4, MemData4, MemAddr4); end
    step();
    checks++; if (MemWE4 !== 1'b0 || Full4 !== 1'b1 || InReady4 !== 1'b0) begin
      errors++; $display("FAIL d4_full got we=%b full=%b ready=%b want 0 1 0", MemWE4, Full4, InReady4); end
    checks++; if (WordCount4 !== 3'd4 || MemAddr4 !== 2'd3) begin errors++; $display("FAIL d4_count got count=%0d addr=%0d want 4 3", WordCount4, MemAddr4); end
    step();
    checks++; if (MemWE4 !== 1'b0 || Full4 !== 1'b1) begin errors++; $display("FAIL d4_hold got we=%b full=%b want 0 1", MemWE4, Full4); end
    Restart4 = 1'b1;
    step();
    Restart4 = 1'b0;
    checks++; if (Full4 !== 1'b0 || MemAddr4 !== 2'd0 || WordCount4 !== 3'd0) begin
      errors++; $display("FAIL d4_restart got full=%b addr=%0d count=%0d want 0 0 0", Full4, MemAddr4, WordCount4); end
    InValid4 = 1'b1; InOp4 = 4'd1;
    step();
    InValid4 = 1'b0;
    checks++; if (MemWE4 !== 1'b1 || MemAddr4 !== 2'd0 || MemData4 !== 32'h0022_1820) begin
      errors++; $display("FAIL d4_after got we=%b %h@%0d want 1 00221820@0", MemWE4, MemData4, MemAddr4); end
  endtask

  task automatic test_random_fill();
    logic [39:0] exp_q[$];
    logic [31:0] w;
    int next_addr = 0;
    int err_exp = 0;
    int cyc = 0;
    bit pending = 1'b0;
    do_reset();
    cap_q.delete();
    err_seen = 0;
    mon_en = 1'b1;
    while (next_addr < 256 && cyc < 4000) begin
      if (!pending) begin
        if ($urandom_range(0, 9) < 7) begin
          drive(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                16'($urandom), 26'($urandom));
        end else begin
          InValid = 1'b0;
        end
      end
      #1;
      if (InValid && InReady) begin
        pending = 1'b0;
        if (InOp > 4'd12) begin
          err_exp++;
        end else begin
          w = model_word(InOp, InRs, InRt, InRd, InImm, InTarget);
          exp_q.push_back({8'(next_addr), w});
          next_addr++;
          if (InOp == 4'd10 && next_addr < 256) begin
            exp_q.push_back({8'(next_addr), 32'h0});
            next_addr++;
          end
        end
      end else begin
        pending = InValid;
      end
      step();
      cyc++;
    end
    InValid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    mon_en = 1'b0;
    checks++; if (next_addr < 256) begin errors++; $display("FAIL rnd_timeout got %0d words want 256", next_addr); end
    checks++; if (cap_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_nwrites got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
      checks++; if (cap_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL rnd_write%0d got %h@%0d want %h@%0d", k, cap_q[k][31:0], cap_q[k][39:32], exp_q[k][31:0], exp_q[k][39:32]); end
    end
    checks++; if (Full !== 1'b1 || InReady !== 1'b0) begin errors++; $display("FAIL rnd_full got full=%b ready=%b want 1 0", Full, InReady); end
    checks++; if (WordCount !== 9'd256 || MemAddr !== 8'd255) begin errors++; $display("FAIL rnd_sat got count=%0d addr=%0d want 256 255", WordCount, MemAddr); end
    checks++; if (err_seen != err_exp) begin errors++; $display("FAIL rnd_errs got %0d want %0d", err_seen, err_exp); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_jump_pad();
    test_illegal();
    test_restart();
    test_full_depth4();
    test_random_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
